// File: rtl/pid_pkg.sv
// Shared types, gain-select codes and helpers for the time-multiplexed PID controller.
package pid_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StMulP,
        StMulI,
        StMulD,
        StOut
    } state_t;

    localparam logic [1:0] CFG_KP = 2'd0;
    localparam logic [1:0] CFG_KI = 2'd1;
    localparam logic [1:0] CFG_KD = 2'd2;

    // Channel index width; a single channel still gets a 1-bit field.
    function automatic int unsigned ch_w(input int unsigned n);
        return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
    endfunction

    function automatic logic signed [63:0] clamp(input logic signed [63:0] v,
                                                 input logic signed [63:0] lo,
                                                 input logic signed [63:0] hi);
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/pid_mac.sv
// Registered signed multiply-accumulate; the only multiplier in the PID datapath.
module pid_mac #(
    parameter int unsigned A_W   = 17,
    parameter int unsigned B_W   = 18,
    parameter int unsigned ACC_W = 36
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_en,
    input  logic                    i_clr,
    input  logic signed [A_W-1:0]   i_a,
    input  logic signed [B_W-1:0]   i_b,
    output logic signed [ACC_W-1:0] o_acc
);

    logic signed [A_W+B_W-1:0] w_prod;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [ACC_W-1:0]   r_acc;

    assign w_prod     = (A_W+B_W)'(i_a) * (A_W+B_W)'(i_b);
    assign w_prod_ext = ACC_W'(w_prod);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= i_clr ? w_prod_ext : r_acc + w_prod_ext;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/pid_mux_ctrl.sv
// Multi-channel PID controller: one shared MAC runs CH_NUM loops per start pulse,
// five cycles per channel, with integrator clamp, anti-windup and output saturation.
module pid_mux_ctrl
    import pid_pkg::*;
#(
    parameter int unsigned              CH_NUM  = 4,
    parameter int unsigned              DATA_W  = 16,
    parameter int unsigned              GAIN_W  = 16,
    parameter int unsigned              FRAC    = 8,
    parameter logic signed [DATA_W-1:0] INT_LIM = 16'sd8192,
    parameter logic signed [DATA_W-1:0] OUT_MAX = 16'sd32767,
    parameter logic signed [DATA_W-1:0] OUT_MIN = -16'sd32768
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_we,
    input  logic [ch_w(CH_NUM)-1:0]    cfg_ch,
    input  logic [1:0]                 cfg_sel,
    input  logic [GAIN_W-1:0]          cfg_data,
    input  logic                       clr_int,
    input  logic                       start,
    input  logic [CH_NUM*DATA_W-1:0]   target,
    input  logic [CH_NUM*DATA_W-1:0]   current,
    output logic                       busy,
    output logic                       out_valid,
    output logic [ch_w(CH_NUM)-1:0]    out_ch,
    output logic signed [DATA_W-1:0]  out_data,
    output logic                       done
);

    localparam int unsigned CH_W  = ch_w(CH_NUM);
    localparam int unsigned ACC_W = GAIN_W + DATA_W + 4;
    localparam int unsigned E_W   = DATA_W + 1;
    localparam int unsigned D_W   = DATA_W + 2;

    state_t                     r_state;
    logic [CH_W-1:0]            r_ch;
    logic [CH_NUM*DATA_W-1:0]   r_target;
    logic [CH_NUM*DATA_W-1:0]   r_current;
    logic [GAIN_W-1:0]          r_kp [CH_NUM];
    logic [GAIN_W-1:0]          r_ki [CH_NUM];
    logic [GAIN_W-1:0]          r_kd [CH_NUM];
    logic signed [DATA_W-1:0]   r_integ [CH_NUM];
    logic signed [E_W-1:0]      r_prev [CH_NUM];
    logic [CH_NUM-1:0]          r_sat_hi;
    logic [CH_NUM-1:0]          r_sat_lo;
    logic signed [E_W-1:0]      r_e;
    logic                       r_busy;
    logic                       r_out_valid;
    logic                       r_done;
    logic [CH_W-1:0]            r_out_ch;
    logic signed [DATA_W-1:0]   r_out_data;

    logic signed [DATA_W-1:0]   w_tgt;
    logic signed [DATA_W-1:0]   w_cur;
    logic signed [E_W-1:0]      w_e;
    logic signed [D_W-1:0]      w_int_sum;
    logic signed [D_W-1:0]      w_diff;
    logic signed [DATA_W-1:0]   w_int_clamped;
    logic signed [DATA_W-1:0]   w_integ_new;
    logic                       w_hold;
    logic                       w_last;
    logic                       w_cfg_ok;
    logic signed [ACC_W-1:0]    w_acc;
    logic signed [ACC_W-1:0]    w_shift;
    logic signed [63:0]         w_shift64;
    logic signed [DATA_W-1:0]   w_y;
    logic                       w_y_hi;
    logic                       w_y_lo;
    logic                       w_mac_en;
    logic                       w_mac_clr;
    logic [GAIN_W-1:0]          w_gain;
    logic signed [GAIN_W:0]     w_mac_a;
    logic signed [D_W-1:0]      w_opnd;

    assign w_tgt = r_target[r_ch*DATA_W +: DATA_W];
    assign w_cur = r_current[r_ch*DATA_W +: DATA_W];
    assign w_e   = E_W'(w_tgt) - E_W'(w_cur);

    assign w_int_sum     = D_W'(r_integ[r_ch]) + D_W'(r_e);
    assign w_int_clamped = DATA_W'(clamp(64'(w_int_sum), -64'(INT_LIM), 64'(INT_LIM)));
    // Stop integrating further into a clamp the output already sits on.
    assign w_hold        = (r_sat_hi[r_ch] && !r_e[E_W-1] && (r_e != '0)) ||
                           (r_sat_lo[r_ch] && r_e[E_W-1]);
    assign w_integ_new   = w_hold ? r_integ[r_ch] : w_int_clamped;
    assign w_diff        = D_W'(r_e) - D_W'(r_prev[r_ch]);

    assign w_shift   = w_acc >>> FRAC;
    assign w_shift64 = 64'(w_shift);
    assign w_y_hi    = w_shift64 > 64'(OUT_MAX);
    assign w_y_lo    = w_shift64 < 64'(OUT_MIN);
    assign w_y       = DATA_W'(clamp(w_shift64, 64'(OUT_MIN), 64'(OUT_MAX)));

    assign w_last   = (r_ch == CH_W'(CH_NUM - 1));
    assign w_cfg_ok = cfg_we && (32'(cfg_ch) < CH_NUM);

    always_comb begin
        w_mac_en  = 1'b0;
        w_mac_clr = 1'b0;
        w_gain    = '0;
        w_opnd    = '0;
        unique case (r_state)
            StMulP: begin
                w_mac_en  = 1'b1;
                w_mac_clr = 1'b1;
                w_gain    = r_kp[r_ch];
                w_opnd    = D_W'(r_e);
            end
            StMulI: begin
                w_mac_en = 1'b1;
                w_gain   = r_ki[r_ch];
                w_opnd   = D_W'(w_integ_new);
            end
            StMulD: begin
                w_mac_en = 1'b1;
                w_gain   = r_kd[r_ch];
                w_opnd   = w_diff;
            end
            default: ;
        endcase
    end

    assign w_mac_a = signed'({1'b0, w_gain});

    pid_mac #(
        .A_W   (GAIN_W + 1),
        .B_W   (D_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_mac_en),
        .i_clr (w_mac_clr),
        .i_a   (w_mac_a),
        .i_b   (w_opnd),
        .o_acc (w_acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_ch        <= '0;
            r_target    <= '0;
            r_current   <= '0;
            r_e         <= '0;
            r_sat_hi    <= '0;
            r_sat_lo    <= '0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_out_ch    <= '0;
            r_out_data  <= '0;
            for (int k = 0; k < int'(CH_NUM); k++) begin
                r_kp[k]    <= '0;
                r_ki[k]    <= '0;
                r_kd[k]    <= '0;
                r_integ[k] <= '0;
                r_prev[k]  <= '0;
            end
        end else begin
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (clr_int) begin
                        r_sat_hi <= '0;
                        r_sat_lo <= '0;
                        for (int k = 0; k < int'(CH_NUM); k++) begin
                            r_integ[k] <= '0;
                            r_prev[k]  <= '0;
                        end
                    end
                    if (w_cfg_ok) begin
                        case (cfg_sel)
                            CFG_KP:  r_kp[cfg_ch] <= cfg_data;
                            CFG_KI:  r_ki[cfg_ch] <= cfg_data;
                            CFG_KD:  r_kd[cfg_ch] <= cfg_data;
                            default: ;
                        endcase
                    end
                    if (start) begin
                        r_target  <= target;
                        r_current <= current;
                        r_ch      <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= StLoad;
                    end
                end
                StLoad: begin
                    r_e     <= w_e;
                    r_state <= StMulP;
                end
                StMulP: r_state <= StMulI;
                StMulI: begin
                    r_integ[r_ch] <= w_integ_new;
                    r_state       <= StMulD;
                end
                StMulD: begin
                    r_prev[r_ch] <= r_e;
                    r_state      <= StOut;
                end
                StOut: begin
                    r_out_valid    <= 1'b1;
                    r_out_ch       <= r_ch;
                    r_out_data     <= w_y;
                    r_sat_hi[r_ch] <= w_y_hi;
                    r_sat_lo[r_ch] <= w_y_lo;
                    if (w_last) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end else begin
                        r_ch    <= r_ch + 1'b1;
                        r_state <= StLoad;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign out_ch    = r_out_ch;
    assign out_data  = r_out_data;
    assign done      = r_done;

endmodule

// File: tb/tb_pid_mux_ctrl.sv
// Directed and randomized bench for pid_mux_ctrl against a per-run arithmetic PID model.
module tb_pid_mux_ctrl;

    localparam int CH = 4;
    localparam int DW = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 cfg_we;
    logic [1:0]           cfg_ch;
    logic [1:0]           cfg_sel;
    logic [15:0]          cfg_data;
    logic                 clr_int;
    logic                 start;
    logic [CH*DW-1:0]     target;
    logic [CH*DW-1:0]     current;
    logic                 busy;
    logic                 out_valid;
    logic [1:0]           out_ch;
    logic signed [15:0]   out_data;
    logic                 done;

    pid_mux_ctrl #(
        .CH_NUM (CH),
        .DATA_W (DW),
        .GAIN_W (16),
        .FRAC   (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_sel   (cfg_sel),
        .cfg_data  (cfg_data),
        .clr_int   (clr_int),
        .start     (start),
        .target    (target),
        .current   (current),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_data  (out_data),
        .done      (done)
    );

    always #5 clk = ~clk;

    int     errors = 0;
    int     checks = 0;
    int     tgt [CH];
    int     cur [CH];
    longint m_kp [CH];
    longint m_ki [CH];
    longint m_kd [CH];
    longint m_integ [CH];
    longint m_prev [CH];
    bit     m_hi [CH];
    bit     m_lo [CH];
    longint exp_y [CH];
    longint got_y [CH];

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint clampl(input longint v, input longint lo, input longint hi);
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < CH; k++) begin
            m_kp[k] = 0; m_ki[k] = 0; m_kd[k] = 0;
            m_integ[k] = 0; m_prev[k] = 0; m_hi[k] = 0; m_lo[k] = 0;
        end
    endtask

    // One full run of every channel, straight from the control law.
    task automatic model_run(input bit clr);
        longint e, acc, y;
        bit hold;
        if (clr) begin
            for (int k = 0; k < CH; k++) begin
                m_integ[k] = 0; m_prev[k] = 0; m_hi[k] = 0; m_lo[k] = 0;
            end
        end
        for (int k = 0; k < CH; k++) begin
            e = longint'(tgt[k]) - longint'(cur[k]);
            hold = (m_hi[k] && e > 0) || (m_lo[k] && e < 0);
            if (!hold) m_integ[k] = clampl(m_integ[k] + e, -8192, 8192);
            acc = m_kp[k] * e + m_ki[k] * m_integ[k] + m_kd[k] * (e - m_prev[k]);
            m_prev[k] = e;
            y = acc >>> 8;
            m_hi[k] = (y > 32767);
            m_lo[k] = (y < -32768);
            exp_y[k] = clampl(y, -32768, 32767);
        end
    endtask

    task automatic pack();
        for (int k = 0; k < CH; k++) begin
            target[k*DW +: DW]  = 16'(tgt[k]);
            current[k*DW +: DW] = 16'(cur[k]);
        end
    endtask

    task automatic set_gain(input int ch, input int sel, input int val);
        @(negedge clk);
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_sel = 2'(sel); cfg_data = 16'(val);
        @(negedge clk);
        cfg_we = 1'b0;
        case (sel)
            0: m_kp[ch] = longint'(val);
            1: m_ki[ch] = longint'(val);
            2: m_kd[ch] = longint'(val);
            default: ;
        endcase
    endtask

    task automatic set_vec(input int t0, input int t1, input int t2, input int t3);
        tgt[0] = t0; tgt[1] = t1; tgt[2] = t2; tgt[3] = t3;
        for (int k = 0; k < CH; k++) cur[k] = 0;
    endtask

    // Starts a run and checks every cycle of it; disturb pokes start/cfg/inputs mid-run.
    task automatic run(input bit clr, input bit disturb);
        int k;
        @(negedge clk);
        pack();
        start = 1'b1;
        clr_int = clr;
        model_run(clr);
        @(posedge clk); #1;
        check("busy_at_start", busy, 1);
        @(negedge clk);
        start = 1'b0;
        clr_int = 1'b0;
        for (int n = 1; n <= 5 * CH; n++) begin
            @(posedge clk); #1;
            if (n % 5 == 0) begin
                k = n / 5 - 1;
                check("out_valid", out_valid, 1);
                check("out_ch", out_ch, k);
                check("out_data", out_data, exp_y[k]);
                check("done", done, (k == CH - 1) ? 1 : 0);
                got_y[k] = longint'(out_data);
            end else begin
                check("valid_idle", out_valid, 0);
                check("done_idle", done, 0);
            end
            if (disturb && n == 2) begin
                @(negedge clk);
                start = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd0; cfg_sel = 2'd0; cfg_data = 16'h1234;
                for (int j = 0; j < CH; j++) tgt[j] = int'($urandom_range(0, 4000)) - 2000;
                pack();
            end
            if (disturb && n == 3) begin
                @(negedge clk);
                start = 1'b0; cfg_we = 1'b0;
            end
        end
        check("busy_end", busy, 0);
        @(posedge clk); #1;
        check("valid_one_cycle", out_valid, 0);
        check("data_hold", out_data, exp_y[CH-1]);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_data = '0;
        clr_int = 1'b0; start = 1'b0; target = '0; current = '0;
        model_reset();
        set_vec(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_ch", out_ch, 0);
        check("rst_data", out_data, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Proportional only, channel 0.
        set_gain(0, 0, 256);
        set_vec(100, 0, 0, 0);
        cur[0] = 40;
        run(0, 0);
        check("p_ch0_60", got_y[0], 60);

        // Proportional on every channel, mixed-sign errors.
        for (int k = 1; k < CH; k++) set_gain(k, 0, 256);
        set_vec(10, -20, 30, -40);
        run(0, 0);
        check("p4_ch0", got_y[0], 10);
        check("p4_ch1", got_y[1], -20);
        check("p4_ch2", got_y[2], 30);
        check("p4_ch3", got_y[3], -40);

        // Integral accumulation and clear.
        for (int k = 0; k < CH; k++) set_gain(k, 0, 0);
        set_gain(0, 1, 256);
        set_vec(5, 0, 0, 0);
        run(1, 0);
        check("i_run1", got_y[0], 5);
        run(0, 0);
        check("i_run2", got_y[0], 10);
        run(0, 0);
        check("i_run3", got_y[0], 15);
        run(1, 0);
        check("i_clr", got_y[0], 5);

        // Saturation and anti-windup.
        set_gain(0, 0, 16'h7FFF);
        set_gain(0, 1, 0);
        set_vec(1000, 0, 0, 0);
        run(1, 0);
        check("sat_hi", got_y[0], 32767);
        set_gain(0, 1, 256);
        run(0, 0);
        check("sat_frozen1", got_y[0], 32767);
        run(0, 0);
        check("sat_frozen2", got_y[0], 32767);
        set_vec(-10, 0, 0, 0);
        run(0, 0);
        check("unwind", got_y[0], -290);

        // Derivative only.
        set_gain(0, 0, 0);
        set_gain(0, 1, 0);
        set_gain(0, 2, 256);
        set_vec(50, 0, 0, 0);
        run(1, 0);
        check("d_first", got_y[0], 50);
        set_vec(80, 0, 0, 0);
        run(0, 0);
        check("d_second", got_y[0], 30);

        // Start/config/input changes while busy are ignored; reserved select is ignored.
        run(0, 1);
        set_vec(80, 0, 0, 0);
        run(0, 0);
        check("busy_write_ignored", got_y[0], 0);
        set_gain(0, 3, 16'hFFFF);
        run(0, 0);

        // Randomized gains, setpoints and clears.
        for (int r = 0; r < 20; r++) begin
            if ($urandom_range(0, 1) == 1)
                set_gain(int'($urandom_range(0, CH - 1)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 1023)));
            for (int k = 0; k < CH; k++) begin
                tgt[k] = int'($urandom_range(0, 4000)) - 2000;
                cur[k] = int'($urandom_range(0, 4000)) - 2000;
            end
            run($urandom_range(0, 3) == 0, 0);
        end

        // Reset in the middle of a run.
        for (int k = 0; k < CH; k++) set_gain(k, 0, 256);
        set_vec(7, 8, 9, 10);
        @(negedge clk);
        pack();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_valid", out_valid, 0);
        check("midrst_data", out_data, 0);
        check("midrst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (out_valid || done) seen++;
        end
        check("midrst_no_output", seen, 0);
        model_reset();
        for (int k = 0; k < CH; k++) begin
            tgt[k] = int'($urandom_range(0, 4000)) - 2000;
            cur[k] = 0;
        end
        run(0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pid_mux_ctrl.md
Name: pid_mux_ctrl

Overview:
Multi-channel PID controller for the flight loop. Sits between attitude estimation and the bb_pwm motor drivers. One time-multiplexed multiplier computes CH_NUM independent PID loops per start pulse and emits one saturated output per channel with a channel tag. Generalises the single-axis fixed-gain PID with:
- runtime-programmable per-channel gains
- parametrised width and channel count
- integrator clamp and conditional-integration anti-windup
- output saturation

Parameters:
CH_NUM, 4, number of control channels (≥1)
DATA_W, 16, signed width of target/current/output
GAIN_W, 16, unsigned gain width
FRAC, 8, fractional bits in gains; result is arithmetically shifted right by FRAC
INT_LIM, 16'sd8192, symmetric integrator clamp magnitude
OUT_MAX, 16'sd32767, output upper limit (signed, DATA_W)
OUT_MIN, -16'sd32768, output lower limit (signed, DATA_W)

Ports:
clk  in  1  main clock
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  gain write strobe
cfg_ch  in  $clog2(CH_NUM) (min 1)  channel of gain write
cfg_sel  in  2  0=KP, 1=KI, 2=KD, 3=reserved (write ignored)
cfg_data  in  GAIN_W  gain value
clr_int  in  1  clear all integrators, previous errors and saturation flags
start  in  1  single-cycle request to run all channels
target  in  CH_NUM*DATA_W  signed setpoints; channel k at [k*DATA_W +: DATA_W]
current  in  CH_NUM*DATA_W  signed measurements, same packing as target
busy  out  1  computation in progress
out_valid  out  1  single-cycle strobe for out_data/out_ch
out_ch  out  $clog2(CH_NUM) (min 1)  channel of out_data
out_data  out  DATA_W  signed saturated PID output
done  out  1  pulses together with the last channel's out_valid

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, gains 0, integrators 0, prev_err 0, sat flags 0.
- FSM states: IDLE, LOAD, MUL_P, MUL_I, MUL_D, OUT. One multiply per MUL_* cycle.
- IDLE + start=1 at edge T0: snapshot all target/current into registers; ch=0; busy=1 from T0.
- Per channel, one state per cycle: LOAD → MUL_P → MUL_I → MUL_D → OUT.
- After OUT: if ch<CH_NUM-1, then ch+1 and go to LOAD; otherwise go to IDLE with busy=0.
- Channel 0 out_valid is high in the 5th cycle after the start edge. Total run is CH_NUM*5 cycles.
- LOAD: e = target-current, computed at DATA_W+1 bits signed (no overflow).
- MUL_P: acc = KP*e. acc is signed, ACC_W = GAIN_W+DATA_W+4. Gains are treated as unsigned and zero-extended.
- MUL_I: candidate i = integ+e, clamped to ±INT_LIM.
  - Anti-windup: if sat_hi[ch] and e>0, or sat_lo[ch] and e<0, the integrator holds its old value.
  - acc += KI*integ (using the updated or held value).
- MUL_D: acc += KD*(e-prev_err[ch]); then prev_err[ch] = e. The difference is DATA_W+2 bits.
- OUT: y = acc>>>FRAC, clamped to [OUT_MIN, OUT_MAX].
  - sat_hi[ch]/sat_lo[ch] record whether the clamp was hit.
  - out_data=y, out_ch=ch, out_valid=1 for exactly 1 cycle.
  - out_data and out_ch hold until the next OUT.
- start while busy: ignored; no queueing.
- cfg_we while busy: ignored. cfg_we in IDLE: gain updated at that edge and used by the next run.
- clr_int: acted on only in IDLE.
  - If start and clr_int arrive together in IDLE, the clear is applied first.
  - The run then starts with cleared state.
- Reset mid-run: all state is discarded immediately; no out_valid or done follows.
- CH_NUM=1: out_ch is tied 0; done coincides with every out_valid.

Decomposition:
- Package pid_pkg:
  - state_t enum
  - CFG_KP/CFG_KI/CFG_KD constants
  - clamp function (signed value, lo, hi)
- Natural sub-module pid_mac: registered signed multiply-accumulate with a clear/accumulate select. Isolates the single multiplier for DSP inference.

Test Plan:
- Reset, then KP=256, KI=0, KD=0 on ch0; target=100, current=40; start → out_ch=0, out_data=60 at cycle 5 after start.
- CH_NUM=4, all channels KP=256, errors 10/-20/30/-40 → out_valid at cycles 5/10/15/20 with values 10/-20/30/-40; done with ch3; busy low afterwards.
- KP=0, KI=256, error=+5, 3 consecutive starts → outputs 5, 10, 15. Then clr_int and start → 5.
- KP=0x7FFF, error=+1000 → out_data=32767 and sat_hi set. Then KI=256 with further starts at the same error → integrator stays frozen, output stays 32767. error=-10 → integrator decrements.
- KD=256 only: error 50 then 80 → outputs 50, then 30.
- Gain write and start issued while busy → both ignored (output sequence unchanged). rst_n pulsed low mid-run → outputs 0 at once, no done.
